// File: rtl/gmii_tx_hub_pkg.sv
// gmii_hub_pkg: shared FSM state type and preamble/SFD constants for the GMII TX hub.
// Ports: none (package).
package gmii_hub_pkg;
    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, IFG} hub_state_e;
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         PREAMBLE_LEN  = 8;
endpackage

// File: rtl/gmii_tx_hub_if.sv
// gmii_tx_hub_if: byte-stream sources on one side, GMII transmitter outputs on the other.
// Ports: src_valid/src_last/src_data/src_ready per source port (port i data = bits [8i+7:8i]);
//        gmii_en/gmii_er/gmii_dout and underrun_cnt from the hub.
//        master = source/observer side, slave = hub side.
interface gmii_tx_hub_if #(
    parameter int N = 2
);
    logic [N-1:0]   src_valid;
    logic [N-1:0]   src_last;
    logic [8*N-1:0] src_data;
    logic [N-1:0]   src_ready;
    logic           gmii_en;
    logic           gmii_er;
    logic [7:0]     gmii_dout;
    logic [15:0]    underrun_cnt;

    modport master (
        output src_valid, src_last, src_data,
        input  src_ready, gmii_en, gmii_er, gmii_dout, underrun_cnt
    );

    modport slave (
        input  src_valid, src_last, src_data,
        output src_ready, gmii_en, gmii_er, gmii_dout, underrun_cnt
    );
endinterface

// File: rtl/gmii_tx_hub_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the lowest requesting index strictly after last_grant.
// Ports: req_i        per-port request
//        last_grant_i index granted most recently
//        any_o        at least one request present
//        grant_o      winning port index
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_grant_i,
    output logic          any_o,
    output logic [IW-1:0] grant_o
);
    logic [IW-1:0] idx;

    assign any_o = |req_i;

    // Scan from farthest to nearest so the closest requester after last_grant overwrites last.
    always_comb begin
        idx     = '0;
        grant_o = last_grant_i;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(last_grant_i) + k) % N);
            if (req_i[idx]) grant_o = idx;
        end
    end
endmodule

// File: rtl/gmii_tx_hub.sv
// gmii_tx_hub: round-robin, whole-frame merge of NUM_PORTS byte streams onto one GMII transmitter.
// Ports: gmii_gtx_clk_i  TX clock, rising edge
//        sys_rst_i       asynchronous active-high reset
//        bus (slave)     src_valid/src_last/src_data in, combinational src_ready out;
//                        registered gmii_en/gmii_er/gmii_dout, saturating underrun_cnt out
module gmii_tx_hub
    import gmii_hub_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int IFG_CYCLES  = 12,
    parameter int PREAMBLE_EN = 1
) (
    input logic          gmii_gtx_clk_i,
    input logic          sys_rst_i,
    gmii_tx_hub_if.slave bus
);
    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = $clog2(IFG_CYCLES);

    hub_state_e    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d, last_q, last_d, arb_grant;
    logic [2:0]    pre_q, pre_d;
    logic [CW-1:0] ifg_q, ifg_d;
    logic          en_q, en_d, er_q, er_d;
    logic [7:0]    dout_q, dout_d;
    logic [15:0]   urun_q, urun_d;
    logic          arb_any, sel_valid, sel_last;
    logic [7:0]    sel_data;

    rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_arb (
        .req_i        (bus.src_valid),
        .last_grant_i (last_q),
        .any_o        (arb_any),
        .grant_o      (arb_grant)
    );

    assign sel_valid        = bus.src_valid[grant_q];
    assign sel_last         = bus.src_last[grant_q];
    assign sel_data         = bus.src_data[8*int'(grant_q) +: 8];
    assign bus.src_ready    = (state_q == DATA) ? NUM_PORTS'(1) << grant_q : '0;
    assign bus.gmii_en      = en_q;
    assign bus.gmii_er      = er_q;
    assign bus.gmii_dout    = dout_q;
    assign bus.underrun_cnt = urun_q;

    always_ff @(posedge gmii_gtx_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_PORTS - 1);
            pre_q   <= '0;
            ifg_q   <= '0;
            en_q    <= 1'b0;
            er_q    <= 1'b0;
            dout_q  <= 8'h00;
            urun_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            pre_q   <= pre_d;
            ifg_q   <= ifg_d;
            en_q    <= en_d;
            er_q    <= er_d;
            dout_q  <= dout_d;
            urun_q  <= urun_d;
        end
    end

    // gmii_dout keeps its value whenever nothing new is loaded.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        pre_d   = pre_q;
        ifg_d   = ifg_q;
        en_d    = 1'b0;
        er_d    = 1'b0;
        dout_d  = dout_q;
        urun_d  = urun_q;
        case (state_q)
            IDLE: if (arb_any) begin
                grant_d = arb_grant;
                pre_d   = '0;
                state_d = (PREAMBLE_EN != 0) ? PREAMBLE : DATA;
            end
            PREAMBLE: begin
                en_d    = 1'b1;
                dout_d  = (pre_q == 3'(PREAMBLE_LEN - 1)) ? SFD_BYTE : PREAMBLE_BYTE;
                pre_d   = pre_q + 3'd1;
                state_d = (pre_q == 3'(PREAMBLE_LEN - 1)) ? DATA : PREAMBLE;
            end
            DATA: begin
                en_d = 1'b1;
                if (sel_valid) begin
                    dout_d = sel_data;
                    if (sel_last) begin
                        state_d = IFG;
                        last_d  = grant_q;
                        ifg_d   = '0;
                    end
                end else begin
                    // Source starved mid-frame: flag the byte as errored, keep the frame open.
                    er_d   = 1'b1;
                    dout_d = 8'h00;
                    urun_d = (urun_q == 16'hFFFF) ? urun_q : urun_q + 16'd1;
                end
            end
            IFG: begin
                // IFG_CYCLES-1 cycles here plus the IDLE cycle give exactly IFG_CYCLES idle beats.
                ifg_d   = ifg_q + 1'b1;
                state_d = (ifg_q == CW'(IFG_CYCLES - 2)) ? IDLE : IFG;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_gmii_tx_hub.sv
// tb_gmii_tx_hub: scoreboard bench for gmii_tx_hub (preamble and raw builds).
module tb_gmii_tx_hub;
    typedef struct { int gap; int cyc; logic er; logic [7:0] d; } exp_t;
    typedef struct { int cyc; int sig; int val; } probe_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   vec = 0;
    int   miss = 0;
    int   c0;
    bit   done = 1'b0;
    exp_t   q[2][$];
    probe_t pq[$];
    int     gap[2] = '{1000, 1000};
    string  sig_nm[7] = '{"en", "er", "dout", "ready", "underrun", "raw ready", "raw underrun"};

    logic       sv[2];
    logic       sl[2];
    logic [7:0] sd[2];
    logic       rsv, rsl;
    logic [7:0] rsd;

    gmii_tx_hub_if #(.N(2)) mb();
    gmii_tx_hub_if #(.N(2)) rb();

    assign mb.src_valid = {sv[1], sv[0]};
    assign mb.src_last  = {sl[1], sl[0]};
    assign mb.src_data  = {sd[1], sd[0]};
    assign rb.src_valid = {1'b0, rsv};
    assign rb.src_last  = {1'b0, rsl};
    assign rb.src_data  = {8'h00, rsd};

    gmii_tx_hub #(.NUM_PORTS(2), .IFG_CYCLES(12), .PREAMBLE_EN(1)) dut (
        .gmii_gtx_clk_i (clk),
        .sys_rst_i      (rst),
        .bus            (mb.slave)
    );

    gmii_tx_hub #(.NUM_PORTS(2), .IFG_CYCLES(12), .PREAMBLE_EN(0)) dut_raw (
        .gmii_gtx_clk_i (clk),
        .sys_rst_i      (rst),
        .bus            (rb.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int probe(input int sig);
        case (sig)
            0:       return int'(mb.gmii_en);
            1:       return int'(mb.gmii_er);
            2:       return int'(mb.gmii_dout);
            3:       return int'(mb.src_ready);
            4:       return int'(mb.underrun_cnt);
            5:       return int'(rb.src_ready);
            6:       return int'(rb.underrun_cnt);
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        vec++;
        if (act != req) begin
            miss++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t   e;
        probe_t p;
        logic   en;
        logic [8:0] got;
        for (int s = 0; s < 2; s++) begin
            en  = (s == 0) ? mb.gmii_en : rb.gmii_en;
            got = (s == 0) ? {mb.gmii_er, mb.gmii_dout} : {rb.gmii_er, rb.gmii_dout};
            if (en) begin
                if (q[s].size() == 0) begin
                    chk($sformatf("stream%0d unexpected byte", s), int'(got), -1);
                end else begin
                    e = q[s].pop_front();
                    chk($sformatf("stream%0d {er,dout}", s), int'(got), int'({e.er, e.d}));
                    if (e.gap >= 0) chk($sformatf("stream%0d idle gap", s), gap[s], e.gap);
                    if (e.cyc >= 0) chk($sformatf("stream%0d first-byte cycle", s), cyc, e.cyc);
                end
                gap[s] = 0;
            end else begin
                gap[s]++;
            end
        end
        while (pq.size() != 0 && pq[0].cyc <= cyc) begin
            p = pq.pop_front();
            chk($sformatf("%s @%0d", sig_nm[p.sig], p.cyc), probe(p.sig), p.val);
        end
        if (done) begin
            chk("main leftover", q[0].size(), 0);
            chk("raw leftover", q[1].size(), 0);
            chk("probe leftover", pq.size(), 0);
            $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required finish");
        $fatal(1, "watchdog");
    end

    task automatic pr(input int c, input int sig, input int val);
        pq.push_back('{cyc: c, sig: sig, val: val});
    endtask

    task automatic reset_probes(input int c);
        for (int s = 0; s < 5; s++) pr(c, s, 0);
    endtask

    task automatic exp_frame(input int first, input int g, input logic [63:0] d, input int n,
                             input int hole_at, input int hole_len);
        for (int k = 0; k < 8; k++)
            q[0].push_back('{gap: (k == 0) ? g : -1, cyc: (k == 0) ? first : -1,
                             er: 1'b0, d: (k == 7) ? 8'hD5 : 8'h55});
        for (int k = 0; k < n; k++) begin
            if (k == hole_at)
                for (int h = 0; h < hole_len; h++) q[0].push_back('{gap: -1, cyc: -1, er: 1'b1, d: 8'h00});
            q[0].push_back('{gap: -1, cyc: -1, er: 1'b0, d: d[8*k +: 8]});
        end
    endtask

    task automatic wait_ready(input int p);
        int w;
        w = 0;
        @(negedge clk);
        while (!mb.src_ready[p]) begin
            w++;
            if (w > 300) begin
                $display("FAIL port%0d ready wait: got 0 for 300 cycles, required 1", p);
                $fatal(1, "ready timeout");
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int p, input logic [63:0] d, input int n,
                        input int hole_at, input int hole_len, input bit no_last);
        for (int k = 0; k < n; k++) begin
            if (k == hole_at) begin
                sv[p] = 1'b0;
                repeat (hole_len) @(posedge clk);
                #1;
            end
            sv[p] = 1'b1;
            sd[p] = d[8*k +: 8];
            sl[p] = !no_last && (k == n - 1);
            wait_ready(p);
        end
        sv[p] = 1'b0;
        sl[p] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        sv  = '{1'b0, 1'b0};
        sl  = '{1'b0, 1'b0};
        sd  = '{8'h00, 8'h00};
        rsv = 1'b0;
        rsl = 1'b0;
        rsd = 8'h00;
        idle(1);
        reset_probes(cyc);
        pr(cyc, 5, 0);
        idle(1);
        rst = 1'b0;

        // single port, 4-byte frame with preamble
        c0 = cyc;
        exp_frame(c0 + 2, -1, 64'h04030201, 4, -1, 0);
        send(0, 64'h04030201, 4, -1, 0, 1'b0);
        idle(20);
        pr(cyc, 2, 8'h04);
        idle(1);

        // both ports valid right after reset: p0, p1, then p0 again
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        c0 = cyc;
        exp_frame(c0 + 2, -1, 64'h121110, 3, -1, 0);
        exp_frame(-1, 12, 64'h222120, 3, -1, 0);
        exp_frame(-1, 12, 64'h3130, 2, -1, 0);
        fork
            begin
                send(0, 64'h121110, 3, -1, 0, 1'b0);
                send(0, 64'h3130, 2, -1, 0, 1'b0);
            end
            send(1, 64'h222120, 3, -1, 0, 1'b0);
        join
        idle(20);

        // underrun: valid dropped for 3 cycles before the third byte
        exp_frame(-1, -1, 64'h43424140, 4, 2, 3);
        send(0, 64'h43424140, 4, 2, 3, 1'b0);
        pr(cyc, 4, 3);
        idle(20);

        // reset mid-DATA on a port 1 frame, then port 0 must win first
        c0 = cyc;
        q[0].push_back('{gap: -1, cyc: c0 + 2, er: 1'b0, d: 8'h55});
        for (int k = 1; k < 7; k++) q[0].push_back('{gap: -1, cyc: -1, er: 1'b0, d: 8'h55});
        q[0].push_back('{gap: -1, cyc: -1, er: 1'b0, d: 8'hD5});
        q[0].push_back('{gap: -1, cyc: -1, er: 1'b0, d: 8'hA0});
        send(1, 64'hA1A0, 2, -1, 0, 1'b1);
        rst = 1'b1;
        reset_probes(cyc);
        idle(2);
        rst = 1'b0;
        c0 = cyc;
        exp_frame(c0 + 2, -1, 64'h5150, 2, -1, 0);
        exp_frame(-1, 12, 64'h60, 1, -1, 0);
        fork
            send(0, 64'h5150, 2, -1, 0, 1'b0);
            send(1, 64'h60, 1, -1, 0, 1'b0);
        join
        idle(20);

        // raw build: single-byte frames back to back
        c0 = cyc;
        q[1].push_back('{gap: -1, cyc: c0 + 2, er: 1'b0, d: 8'h7E});
        q[1].push_back('{gap: 12, cyc: c0 + 15, er: 1'b0, d: 8'h7F});
        pr(c0 + 1, 5, 1);
        pr(c0 + 12, 5, 0);
        pr(c0 + 13, 5, 0);
        pr(c0 + 14, 5, 1);
        pr(c0 + 16, 6, 0);
        rsv = 1'b1;
        rsl = 1'b1;
        rsd = 8'h7E;
        idle(2);
        rsd = 8'h7F;
        idle(13);
        rsv = 1'b0;
        rsl = 1'b0;
        idle(20);
        done = 1'b1;
    end
endmodule
